// File: rtl/uart_cmd_queue.sv
// uart_cmd_queue: 16-bit command FIFO feeding a UART transmitter through an issue/retry/gap FSM.
// Define UART_CMDQ_OVF_CNT_EN to add ovf_cnt, a saturating count of dropped writes.
module uart_cmd_queue #(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [15:0]              wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic [15:0]              cmd_out,
  output logic                     cmd_vld,
  input  logic                     cmd_rdy,
  output logic                     busy
`ifdef UART_CMDQ_OVF_CNT_EN
  ,
  output logic [7:0]               ovf_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;

  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [7:0]    GAP_LAST   = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam logic [1:0]    RETRY_LAST = 2'd3;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_nxt;
  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [7:0]    gap_cnt;
  logic [1:0]    retry_cnt;
  logic          push;
  logic          pop;
  logic          drop;

  assign push = wr_en && !full;
  assign drop = wr_en && full;
  assign pop  = (state == IDLE) && !empty && cmd_rdy;

  always_comb begin
    level_nxt = level;
    if (push && !pop)      level_nxt = level + LW'(1);
    else if (pop && !push) level_nxt = level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      full  <= (level_nxt == FULL_LEVEL);
      empty <= (level_nxt == '0);
      ovf   <= drop;
    end
  end

  // A transmitter that never drops cmd_rdy after a strobe gets the same command re-strobed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!empty && cmd_rdy) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!cmd_rdy)                      state_nxt = WAIT_DONE;
        else if (retry_cnt == RETRY_LAST)  state_nxt = ISSUE;
      end
      WAIT_DONE: if (cmd_rdy) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:       if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cmd_vld   <= 1'b0;
      cmd_out   <= 16'h0000;
      gap_cnt   <= 8'd0;
      retry_cnt <= 2'd0;
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt != IDLE);
      cmd_vld <= (state == ISSUE);
      if (pop) cmd_out <= mem[rd_ptr];
      gap_cnt <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
      if ((state == WAIT_BUSY) && cmd_rdy && (retry_cnt != RETRY_LAST))
        retry_cnt <= retry_cnt + 2'd1;
      else
        retry_cnt <= 2'd0;
    end
  end

`ifdef UART_CMDQ_OVF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          ovf_cnt <= 8'd0;
    else if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_uart_cmd_queue.sv
// Self-checking bench for uart_cmd_queue: vector table, directed corner sequences and a
// randomized run against a queue/timestamp reference model.
module tb_uart_cmd_queue;

  localparam int DEPTH      = 8;
  localparam int GAP_CYCLES = 2;
  localparam int LW         = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [15:0]   wr_data = 16'h0000;
  logic          cmd_rdy = 1'b0;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          ovf;
  logic [15:0]   cmd_out;
  logic          cmd_vld;
  logic          busy;
`ifdef UART_CMDQ_OVF_CNT_EN
  logic [7:0]    ovf_cnt;
`endif

  int errors = 0;
  int checks = 0;

  uart_cmd_queue #(.DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .ovf(ovf),
    .cmd_out(cmd_out), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .busy(busy)
`ifdef UART_CMDQ_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: commands held in a queue; issuer availability tracked as edge timestamps.
  logic [15:0] mq[$];
  int          cyc = 0;
  bit          m_busy = 0;
  bit          m_seen_low = 0;
  int          m_pop_edge = -10;
  int          m_free_at = 0;
  bit          m_ovf = 0;
  logic [15:0] m_cmd = 16'h0000;
  bit          model_chk = 1;

  typedef struct {
    logic        we;
    logic [15:0] wd;
    logic        rdy;
    int          lvl;
    logic        f;
    logic        e;
    logic        o;
    logic        b;
    logic        v;
    logic [15:0] cmd;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] wq[$];
  int          v_at[$];
  logic [15:0] v_cmd[$];
  int          nbusy;
  int          nv;
  int          rt_busy;
  int          rt_hold;
  int          rt_left;
  int          wr_pct;

  function automatic void checkOutput(input string name, input logic [31:0] actual,
                                      input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, actual, expected, cyc);
    end
  endfunction

  function automatic vec_t mkVec(input logic we, input logic [15:0] wd, input logic rdy,
                                 input int lvl, input logic f, input logic e, input logic o,
                                 input logic b, input logic v, input logic [15:0] cmd);
    vec_t r;
    r.we = we; r.wd = wd; r.rdy = rdy; r.lvl = lvl; r.f = f; r.e = e;
    r.o = o; r.b = b; r.v = v; r.cmd = cmd;
    return r;
  endfunction

  task automatic modelEdge();
    int size_before;
    bit pop;
    cyc++;
    if (rst) begin
      mq.delete();
      m_busy = 0; m_seen_low = 0; m_pop_edge = -10; m_free_at = 0;
      m_ovf = 0; m_cmd = 16'h0000;
      return;
    end
    size_before = mq.size();
    if (m_busy && cyc >= m_pop_edge + 2) begin
      if (!m_seen_low && !cmd_rdy) m_seen_low = 1;
      else if (m_seen_low && cmd_rdy) begin
        m_busy = 0;
        m_free_at = cyc + GAP_CYCLES + 1;
      end
    end
    pop = !m_busy && (cyc >= m_free_at) && (size_before > 0) && cmd_rdy;
    m_ovf = wr_en && (size_before == DEPTH);
    if (pop) begin
      m_cmd = mq.pop_front();
      m_busy = 1; m_seen_low = 0; m_pop_edge = cyc;
    end
    if (wr_en && size_before < DEPTH) mq.push_back(wr_data);
  endtask

  task automatic checkModel();
    checkOutput("m_level", 32'(level), 32'(mq.size()));
    checkOutput("m_full", 32'(full), 32'(mq.size() == DEPTH));
    checkOutput("m_empty", 32'(empty), 32'(mq.size() == 0));
    checkOutput("m_ovf", 32'(ovf), 32'(m_ovf));
    checkOutput("m_cmd_vld", 32'(cmd_vld), 32'(cyc == m_pop_edge + 1));
    checkOutput("m_cmd_out", 32'(cmd_out), 32'(m_cmd));
    checkOutput("m_busy", 32'(busy), 32'(m_busy || (cyc < m_free_at - 1)));
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    if (model_chk) checkModel();
  endtask

  task automatic applyStimulus(input logic we, input logic [15:0] wd, input logic rdy);
    wr_en = we; wr_data = wd; cmd_rdy = rdy;
    tick();
  endtask

  task automatic resetDut();
    rst = 1'b1; wr_en = 1'b0; wr_data = 16'h0000; cmd_rdy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Transmitter that drops cmd_rdy for 22 edges right after each strobe; writes come from wq.
  task automatic runFrames(input int ncyc);
    int tx_left = 0;
    v_at.delete(); v_cmd.delete(); nbusy = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (wq.size() > 0) begin
        wr_en = 1'b1; wr_data = wq.pop_front();
      end else begin
        wr_en = 1'b0; wr_data = 16'h0000;
      end
      if (tx_left > 0) begin cmd_rdy = 1'b0; tx_left--; end
      else cmd_rdy = 1'b1;
      tick();
      nbusy += int'(busy);
      if (cmd_vld === 1'b1) begin
        v_at.push_back(k); v_cmd.push_back(cmd_out); tx_left = 22;
      end
    end
    wr_en = 1'b0;
  endtask

  initial begin
    tick();
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_vld", 32'(cmd_vld), 32'd0);
    checkOutput("rst_cmd_out", 32'(cmd_out), 32'h0000);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Fill with the transmitter stalled, overflow, then pop and drop on the same edge.
    for (int i = 0; i < DEPTH; i++)
      vecs.push_back(mkVec(1'b1, 16'hC100 + 16'(i), 1'b0, i + 1, i == DEPTH - 1,
                           1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mkVec(1'b1, 16'hBAD0, 1'b0, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mkVec(1'b0, 16'h0000, 1'b0, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mkVec(1'b1, 16'hBAD1, 1'b1, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hC100));
    vecs.push_back(mkVec(1'b1, 16'hC108, 1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'hC100));
    vecs.push_back(mkVec(1'b0, 16'h0000, 1'b0, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hC100));
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].wd, vecs[i].rdy);
      checkOutput($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].lvl));
      checkOutput($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].f));
      checkOutput($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].e));
      checkOutput($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].o));
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].b));
      checkOutput($sformatf("vec%0d_vld", i), 32'(cmd_vld), 32'(vecs[i].v));
      checkOutput($sformatf("vec%0d_cmd", i), 32'(cmd_out), 32'(vecs[i].cmd));
    end

    resetDut();
    wq = '{16'hA55A};
    runFrames(60);
    checkOutput("lat_pulses", 32'(v_at.size()), 32'd1);
    if (v_at.size() > 0) begin
      checkOutput("lat_edge", 32'(v_at[0]), 32'd2);
      checkOutput("lat_cmd", 32'(v_cmd[0]), 32'hA55A);
    end
    checkOutput("lat_busy_cycles", 32'(nbusy), 32'(2 + 22 + GAP_CYCLES));
    checkOutput("lat_busy_end", 32'(busy), 32'd0);

    resetDut();
    wq = '{16'h0001, 16'h0002, 16'h0003};
    runFrames(120);
    checkOutput("order_pulses", 32'(v_at.size()), 32'd3);
    for (int i = 0; i < v_at.size() && i < 3; i++) begin
      checkOutput($sformatf("order_cmd%0d", i), 32'(v_cmd[i]), 32'(i + 1));
      if (i > 0)
        checkOutput($sformatf("order_spacing%0d", i),
                    32'(v_at[i] - v_at[i-1] >= 22 + GAP_CYCLES), 32'd1);
    end

    resetDut();
    model_chk = 0;
    applyStimulus(1'b1, 16'h1234, 1'b1);
    wr_en = 1'b0;
    v_at.delete(); v_cmd.delete();
    for (int k = 1; k < 25; k++) begin
      tick();
      if (cmd_vld === 1'b1) begin v_at.push_back(k); v_cmd.push_back(cmd_out); end
    end
    checkOutput("retry_pulses", 32'(v_at.size()), 32'd5);
    if (v_at.size() > 0) checkOutput("retry_first", 32'(v_at[0]), 32'd2);
    for (int i = 0; i < v_at.size(); i++) begin
      checkOutput($sformatf("retry_cmd%0d", i), 32'(v_cmd[i]), 32'h1234);
      if (i > 0) checkOutput($sformatf("retry_period%0d", i), 32'(v_at[i] - v_at[i-1]), 32'd5);
    end
    resetDut();
    model_chk = 1;

    wq = '{16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04, 16'h0B05};
    runFrames(8);
    checkOutput("wd_level", 32'(level), 32'd4);
    checkOutput("wd_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("arst_level", 32'(level), 32'd0);
    checkOutput("arst_empty", 32'(empty), 32'd1);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_vld", 32'(cmd_vld), 32'd0);
    checkOutput("arst_cmd_out", 32'(cmd_out), 32'h0000);
    tick();
    rst = 1'b0;
    cmd_rdy = 1'b1;
    nv = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      nv += int'(cmd_vld);
    end
    checkOutput("arst_no_vld", 32'(nv), 32'd0);
    checkOutput("arst_level_after", 32'(level), 32'd0);

    // Randomized traffic with a transmitter that answers each strobe within two edges.
    resetDut();
    rt_busy = 0; rt_hold = 0; rt_left = 0; wr_pct = 30;
    for (int k = 0; k < 2400; k++) begin
      if (k % 300 == 0) wr_pct = $urandom_range(5, 95);
      wr_en = ($urandom_range(0, 99) < wr_pct);
      wr_data = 16'($urandom);
      rst = (k == 1200);
      if (rst) rt_busy = 0;
      if (rt_busy != 0) begin
        if (rt_hold > 0) begin cmd_rdy = 1'b1; rt_hold--; end
        else if (rt_left > 0) begin cmd_rdy = 1'b0; rt_left--; end
        else begin cmd_rdy = 1'b1; rt_busy = 0; end
      end else begin
        cmd_rdy = ($urandom_range(0, 3) != 0);
      end
      tick();
      if (cmd_vld === 1'b1) begin
        rt_busy = 1; rt_hold = $urandom_range(0, 1); rt_left = $urandom_range(1, 25);
      end
    end
    rst = 1'b0;

`ifdef UART_CMDQ_OVF_CNT_EN
    resetDut();
    checkOutput("ovf_cnt_rst", 32'(ovf_cnt), 32'd0);
    for (int k = 0; k < DEPTH + 300; k++) begin
      applyStimulus(1'b1, 16'(k), 1'b0);
      if (k == DEPTH) checkOutput("ovf_cnt_first", 32'(ovf_cnt), 32'd1);
    end
    wr_en = 1'b0;
    tick();
    checkOutput("ovf_cnt_sat", 32'(ovf_cnt), 32'd255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_queue.md
UART_CMD_QUEUE -- requirements
Module: uart_cmd_queue

Interface
REQ-001 Parameter DEPTH, 8, number of 16-bit command entries buffered (power of two, 2..64).
REQ-002 Parameter GAP_CYCLES, 2, idle clk cycles forced between the end of one transmitted command and the next issue (0..255).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 wr_en  input  1  host write strobe; one command per cycle.
REQ-006 wr_data  input  16  host command, same 16-bit layout the UART transmitter consumes.
REQ-007 full  output  1  queue holds DEPTH entries.
REQ-008 empty  output  1  queue holds zero entries.
REQ-009 level  output  clog2(DEPTH)+1  current entry count.
REQ-010 ovf  output  1  one-cycle pulse when a write is dropped.
REQ-011 cmd_out  output  16  command presented to the UART transmitter's cmd_in.
REQ-012 cmd_vld  output  1  one-cycle issue strobe to the transmitter.
REQ-013 cmd_rdy  input  1  transmitter ready; low while a frame is being shifted out.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The block SHALL contain a synchronous FIFO and an issue FSM; all outputs SHALL be registered.
REQ-016 A write with wr_en=1 and full=0 SHALL store wr_data at the tail; level increments on the following edge.
REQ-017 A write with wr_en=1 and full=1 SHALL be dropped and pulse ovf for exactly one cycle; this holds even if a pop occurs in the same cycle.
REQ-018 A simultaneous accepted write and pop SHALL leave level unchanged; read/write pointers wrap modulo DEPTH.
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
REQ-020 IDLE -> ISSUE when empty=0 and cmd_rdy=1; on that edge the head entry loads into cmd_out and is popped.
REQ-021 In ISSUE, cmd_vld SHALL be 1 for exactly one cycle; ISSUE -> WAIT_BUSY unconditionally.
REQ-022 WAIT_BUSY -> WAIT_DONE when cmd_rdy=0; if cmd_rdy stays 1 for 4 cycles, -> ISSUE and re-strobe the same cmd_out (retry).
REQ-023 WAIT_DONE -> GAP when cmd_rdy=1; when GAP_CYCLES=0, go straight to IDLE instead.
REQ-024 GAP SHALL count GAP_CYCLES cycles, then -> IDLE; the counter is cleared on GAP entry.
REQ-025 cmd_out SHALL hold its value from ISSUE until the next IDLE -> ISSUE transition.
REQ-026 Latency: a write accepted at edge N into an empty queue in IDLE with cmd_rdy=1 SHALL produce cmd_vld=1 in the cycle following edge N+2.
REQ-027 With the queue empty, the FSM SHALL remain in IDLE with cmd_vld=0 regardless of cmd_rdy.

Reset
REQ-028 On rst=1, asynchronously: FIFO pointers=0, level=0, empty=1, full=0, ovf=0, cmd_vld=0, cmd_out=16'h0000, busy=0, state=IDLE, GAP and retry counters=0.
REQ-029 Reset asserted mid-operation SHALL discard all queued commands; no cmd_vld is produced until a new write after reset release.
REQ-030 FIFO storage contents need no reset.

Configuration
REQ-031 With macro UART_CMDQ_OVF_CNT_EN defined, an extra output ovf_cnt (8 bits) SHALL count dropped writes, saturate at 255, and reset to 0.
REQ-032 Without UART_CMDQ_OVF_CNT_EN, the ovf_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Single write 16'hA55A, cmd_rdy=1, transmitter model drops cmd_rdy 1 cycle after cmd_vld for 22 cycles -> cmd_out=16'hA55A, one cmd_vld pulse at edge N+2, busy until GAP ends.
REQ-034 Write 9 commands back-to-back with DEPTH=8 and cmd_rdy held 0 -> full=1 after 8, ovf pulses once on the 9th, level=8.
REQ-035 Queue 3 commands 16'h0001..16'h0003 -> issued in order, each pair of cmd_vld pulses separated by at least 22+GAP_CYCLES(2) cycles.
REQ-036 cmd_rdy held 1 after ISSUE (transmitter never accepts) -> cmd_vld re-pulses every 5 cycles with the same cmd_out.
REQ-037 Assert rst during WAIT_DONE with 4 entries queued -> level=0, empty=1, state=IDLE, no further cmd_vld.
REQ-038 With UART_CMDQ_OVF_CNT_EN, 300 writes while full -> ovf_cnt=255 (saturated).
